// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory behind a wait-state controller.
//
// Takes one load/store request at a time from the memory/writeback stage.
// It performs a byte-masked write or a full-word read after WAIT_STATES extra
// cycles. The upstream pipeline is held with `stall` while the access is in
// flight, and completion is signalled with a one-cycle `valid`.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   cs       in   chip select, active low (0 = request present)
//   wr       in   1 = read, 0 = write
//   mask     in   [3:0] byte-lane write enables
//   addr     in   [31:0] byte address; word index = addr[AW+1:2]
//   data_wr  in   [31:0] lane-positioned store data
//   data_rd  out  [31:0] registered read word (held until the next read)
//   valid    out  one-cycle completion pulse
//   stall    out  hold upstream while a request is accepted or waiting
//   fault    out  out-of-range access, qualified by valid

// One byte lane of the memory array: byte-enabled write, asynchronous read.
module dmem_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= din;

  assign dout = mem[idx];
endmodule

module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        valid,
  output logic        stall,
  output logic        fault
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WS        = WAIT_STATES[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                          wr;
    logic [NUM_LANES-1:0]          mask;
    logic [AW-1:0]                 idx;
    logic [NUM_LANES-1:0][7:0]     data;
    logic                          oor;
  } req_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       load, access;
  req_t       req_in, req_q, req_acc;
  logic [NUM_LANES-1:0][7:0] rd_lane;
  logic [NUM_LANES-1:0]      lane_we;

  // addr[1:0] select a byte within the word; the memory is word-wide, so
  // they play no part here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  assign req_in.wr   = wr;
  assign req_in.mask = mask;
  assign req_in.idx  = addr[AW+1:2];
  assign req_in.data = data_wr;
  assign req_in.oor  = |addr[31:AW+2];

  // With zero wait states the access happens on the accept edge, before the
  // latch is loaded, so it has to use the live request.
  assign req_acc = (state == IDLE) ? req_in : req_q;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: if (!cs) begin
        load = 1'b1;
        if (WS == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = WS;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // <= guards against a stray zero count ever stalling forever.
        if (cnt <= 4'd1) begin
          access  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      data_rd <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) req_q <= req_in;
      if (access && req_acc.wr)
        data_rd <= req_acc.oor ? 32'h0 : rd_lane;
    end
  end

  // Reset on the access edge abandons the write entirely.
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_we[i] = rst_n && access && !req_acc.wr && !req_acc.oor
                          && req_acc.mask[i];
      dmem_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
        .clk  (clk),
        .we   (lane_we[i]),
        .idx  (req_acc.idx),
        .din  (req_acc.data[i]),
        .dout (rd_lane[i])
      );
    end
  endgenerate

  assign valid = (state == RESP);
  assign fault = (state == RESP) && req_q.oor;
  assign stall = rst_n && (((state == IDLE) && !cs) || (state == WAIT));
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. Several instances with different
// DEPTH / WAIT_STATES run one after another against a word-array model.
module tb_dmem_ctrl;
  localparam int NI = 5;
  localparam int WS_T[NI] = '{1, 0, 3, 15, 4};
  localparam int DP_T[NI] = '{1024, 1024, 64, 1024, 1024};

  logic        clk = 1'b0;
  logic        rst_n   [NI];
  logic        cs      [NI];
  logic        wr      [NI];
  logic [3:0]  mask    [NI];
  logic [31:0] addr    [NI];
  logic [31:0] data_wr [NI];
  logic [31:0] data_rd [NI];
  logic        valid   [NI];
  logic        stall   [NI];
  logic        fault   [NI];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl     [NI][1024];
  bit          known   [NI][1024];
  logic [31:0] last_rd [NI];
  bit          last_kn [NI];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      dmem_ctrl #(.DEPTH(DP_T[g]), .WAIT_STATES(WS_T[g])) u_dut (
        .clk     (clk),
        .rst_n   (rst_n[g]),
        .cs      (cs[g]),
        .wr      (wr[g]),
        .mask    (mask[g]),
        .addr    (addr[g]),
        .data_wr (data_wr[g]),
        .data_rd (data_rd[g]),
        .valid   (valid[g]),
        .stall   (stall[g]),
        .fault   (fault[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance k, with model update and checks on
  // latency, stall length, fault, data_rd and the pulse width of valid.
  task automatic txn(input int k, input logic w, input logic [3:0] m,
                     input logic [31:0] a, input logic [31:0] d);
    int      ws;
    int      ncyc;
    int      nstall;
    bit      got;
    bit      oor;
    int      word;
    logic [31:0] cur;
    string   p;
    ws  = WS_T[k];
    p   = $sformatf("i%0d a=%h w=%0d", k, a, w);
    oor = (longint'(a) >= longint'(DP_T[k]) * 4);
    word = oor ? 0 : int'(a >> 2);
    if (!oor) begin
      if (!w) begin
        cur = mdl[k][word];
        for (int b = 0; b < 4; b++)
          if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
        mdl[k][word] = cur;
      end else begin
        last_rd[k] = mdl[k][word];
        last_kn[k] = known[k][word];
      end
    end else if (w) begin
      last_rd[k] = 32'h0;
      last_kn[k] = 1'b1;
    end

    @(posedge clk); #1;
    rst_n[k] = 1'b1; cs[k] = 1'b0; wr[k] = w; mask[k] = m; addr[k] = a; data_wr[k] = d;
    @(negedge clk);
    chk({p, " stall_T"}, 32'(stall[k]), 32'd1);
    nstall = stall[k] ? 1 : 0;
    @(posedge clk); #1;
    // Scribble on the inputs; the accepted request must be unaffected.
    cs[k] = 1'b1; wr[k] = 1'($urandom); mask[k] = 4'($urandom);
    addr[k] = $urandom; data_wr[k] = $urandom;
    got = 1'b0; ncyc = 1;
    while (!got && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (valid[k]) got = 1'b1;
      else if (stall[k]) nstall++;
    end
    chk({p, " valid_seen"}, 32'(got), 32'd1);
    chk({p, " latency"}, 32'(ncyc), 32'(ws + 2));
    chk({p, " stall_len"}, 32'(nstall), 32'(ws + 1));
    chk({p, " stall_at_valid"}, 32'(stall[k]), 32'd0);
    chk({p, " fault"}, 32'(fault[k]), 32'(oor));
    if (!w && !oor) known[k][word] = known[k][word] || (m == 4'hF);
    if (last_kn[k]) chk({p, " data_rd"}, data_rd[k], last_rd[k]);
    @(negedge clk);
    chk({p, " valid_pulse"}, 32'(valid[k]), 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr(input int k);
    int sel;
    sel = $urandom_range(0, 17);
    if (sel == 16) return 32'((DP_T[k] - 1) * 4) | 32'($urandom_range(0, 3));
    if (sel == 17) return $urandom | (32'(DP_T[k]) << 2);
    return 32'(sel * 4) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; cs[k] = 1'b0; wr[k] = 1'b1; mask[k] = 4'h0;
      addr[k] = 32'h1000_0000; data_wr[k] = 32'h0;
      last_rd[k] = 32'h0; last_kn[k] = 1'b1;
      for (int j = 0; j < 1024; j++) begin
        mdl[k][j] = 32'h0; known[k][j] = 1'b0;
      end
    end

    // Reset held with cs=0: nothing may be stalled or valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d rst_stall", k), 32'(stall[k]), 32'd0);
      chk($sformatf("i%0d rst_valid", k), 32'(valid[k]), 32'd0);
      chk($sformatf("i%0d rst_fault", k), 32'(fault[k]), 32'd0);
      chk($sformatf("i%0d rst_data", k), data_rd[k], 32'h0);
    end
    // Release: the pending cs=0 request is taken right away.
    for (int k = 0; k < NI; k++) txn(k, 1'b1, 4'h0, 32'h1000_0000, 32'h0);

    // Preload the words the random phase uses.
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 16; j++) txn(k, 1'b0, 4'hF, 32'(j * 4), $urandom);
      txn(k, 1'b0, 4'hF, 32'((DP_T[k] - 1) * 4), $urandom);
    end

    // Directed on the WAIT_STATES=1 instance.
    txn(0, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
    txn(0, 1'b1, 4'h0, 32'h10, 32'h0);
    chk("dir deadbeef", data_rd[0], 32'hDEAD_BEEF);
    txn(0, 1'b0, 4'hF, 32'h20, 32'h1122_3344);
    txn(0, 1'b0, 4'b1010, 32'h22, 32'hAA00_BB00);
    txn(0, 1'b1, 4'hF, 32'h20, 32'h0);
    chk("dir masked", data_rd[0], 32'hAA22_BB44);
    txn(0, 1'b0, 4'h0, 32'h20, 32'hFFFF_FFFF);
    txn(0, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("dir mask0", data_rd[0], 32'hAA22_BB44);
    txn(0, 1'b1, 4'hF, 32'h0000_1000, 32'h0);
    chk("dir fault_rd", data_rd[0], 32'h0);
    txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0BAD_0BAD);
    txn(0, 1'b1, 4'hF, 32'h0, 32'h0);

    // DEPTH=64 boundary: last word in range, first word out of range.
    txn(2, 1'b0, 4'hF, 32'hFC, 32'hCAFE_F00D);
    txn(2, 1'b1, 4'h0, 32'hFC, 32'h0);
    txn(2, 1'b1, 4'h0, 32'h100, 32'h0);

    // Reset in the second WAIT cycle of a write: no completion, no write.
    @(posedge clk); #1;
    cs[4] = 1'b0; wr[4] = 1'b0; mask[4] = 4'hF; addr[4] = 32'h8; data_wr[4] = 32'h5;
    @(negedge clk); chk("rstw stall_T", 32'(stall[4]), 32'd1);
    @(posedge clk); #1; cs[4] = 1'b1;
    @(negedge clk); chk("rstw stall_w1", 32'(stall[4]), 32'd1);
    @(posedge clk); #1; rst_n[4] = 1'b0;
    @(negedge clk); chk("rstw stall_rst", 32'(stall[4]), 32'd0);
    @(posedge clk); #1; rst_n[4] = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (valid[4]) seen = 1'b1;
      end
      chk("rstw no_valid", 32'(seen), 32'd0);
    end
    chk("rstw data_clr", data_rd[4], 32'h0);
    last_rd[4] = 32'h0; last_kn[4] = 1'b1;
    txn(4, 1'b1, 4'h0, 32'h8, 32'h0);

    // Random mix on every instance.
    for (int k = 0; k < NI; k++)
      for (int n = 0; n < 40; n++)
        txn(k, 1'($urandom_range(0, 1)), 4'($urandom), rnd_addr(k), $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
